snake_field_render: RTL

Reader side of the snake coordinate bus. On each snake2field strobe it captures the packed snake_xy array and the length, then walks the segments one per clock. It builds an occupancy bitmap of the SIZE_X×SIZE_Y field, and detects wall and self collisions and food hits. It feeds the display path and returns grow and collision flags to the game controller.

---
 rtl/snake_field_render_pkg.sv | 38 +++
 rtl/snake_field_render_cell_decode.sv | 56 +++++
 rtl/snake_field_render.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/snake_field_render_pkg.sv
`default_nettype none
// ============================================================================
// Package     : snake_pkg
// Description : Shared types and helpers for the snake field renderer.
//               Provides coordinate/segment widths, the renderer state
//               encoding, segment field extraction and cell indexing.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam int COORD_W = 8;
    localparam int SEG_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A segment is {y, x}, one byte each.
    function automatic logic [COORD_W-1:0] seg_x(input logic [SEG_W-1:0] seg);
        return seg[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] seg_y(input logic [SEG_W-1:0] seg);
        return seg[SEG_W-1:COORD_W];
    endfunction

    // Row-major cell index at 16-bit width: y*size_x + x.
    function automatic logic [15:0] cell_idx(input logic [COORD_W-1:0] x,
                                             input logic [COORD_W-1:0] y,
                                             input logic [15:0]        size_x);
        return 16'(y) * size_x + 16'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_field_render_cell_decode.sv
`default_nettype none
// ============================================================================
// Module      : snake_cell_decode
// Description : Combinational decode of one segment coordinate into a
//               bounds flag and a one-hot cell mask over the field.
//               With SNAKE_FIELD_WRAP_EN defined the coordinate is first
//               reduced onto the torus (0xFF -> SIZE-1, >=SIZE -> -SIZE).
// Ports       : x, y         - raw segment coordinate
//               x_red, y_red - coordinate after optional wrap reduction
//               in_bounds    - reduced coordinate lies inside the field
//               mask         - one-hot cell bit, zero when out of bounds
// Macro       : SNAKE_FIELD_WRAP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module snake_cell_decode
    import snake_pkg::*;
#(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10,
    parameter int CELLS  = SIZE_X * SIZE_Y
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] x_red,
    output logic [COORD_W-1:0] y_red,
    output logic               in_bounds,
    output logic [CELLS-1:0]   mask
);

    localparam logic [COORD_W-1:0] c_size_x = COORD_W'(SIZE_X);
    localparam logic [COORD_W-1:0] c_size_y = COORD_W'(SIZE_Y);
    localparam logic [CELLS-1:0]   c_one    = CELLS'(1);

    logic [15:0] w_idx;

`ifdef SNAKE_FIELD_WRAP_EN
    // 0xFF is the underflow of a decrement at coordinate 0.
    always_comb begin
        if (x == 8'hFF)          x_red = c_size_x - 8'd1;
        else if (x >= c_size_x)  x_red = x - c_size_x;
        else                     x_red = x;
        if (y == 8'hFF)          y_red = c_size_y - 8'd1;
        else if (y >= c_size_y)  y_red = y - c_size_y;
        else                     y_red = y;
    end
`else
    assign x_red = x;
    assign y_red = y;
`endif

    assign in_bounds = (x_red < c_size_x) && (y_red < c_size_y);
    assign w_idx     = cell_idx(x_red, y_red, 16'(SIZE_X));
    assign mask      = in_bounds ? (c_one << w_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/snake_field_render.sv
`default_nettype none
// ============================================================================
// Module      : snake_field_render
// Description : Reader side of the snake coordinate bus. Captures the
//               packed segment array on a snake2field strobe, walks one
//               segment per clock into a working occupancy bitmap, and
//               publishes the bitmap plus grow/collision flags on done.
// Ports       : clk, rst (sync, active low)
//               snake2field - capture strobe for snake_xy / lengh
//               lengh       - valid segment count (clamped to CELLS)
//               snake_xy    - packed {y,x} segments, index 0 is the head
//               food_x/y    - food cell
//               field       - occupancy bitmap, bit y*SIZE_X+x
//               busy, done  - scan in progress / one-cycle completion pulse
//               grow, collision - frame result, held until next done
// Macro       : SNAKE_FIELD_WRAP_EN (toroidal field, no wall collisions)
// Revision    : 1.0 - initial release
// ============================================================================
module snake_field_render
    import snake_pkg::*;
#(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int CELLS      = SIZE_X * SIZE_Y,
    parameter int SNAKE_SIZE = 16 * CELLS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snake2field,
    input  logic [15:0]           lengh,
    input  logic [SNAKE_SIZE-1:0] snake_xy,
    input  logic [COORD_W-1:0]    food_x,
    input  logic [COORD_W-1:0]    food_y,
    output logic [CELLS-1:0]      field,
    output logic                  busy,
    output logic                  done,
    output logic                  grow,
    output logic                  collision
);

    localparam logic [15:0] c_cells = 16'(CELLS);

    state_t                r_state;
    logic [SNAKE_SIZE-1:0] r_snake_xy;
    logic [15:0]           r_len;
    logic [15:0]           r_idx;
    logic [CELLS-1:0]      r_work;
    logic [COORD_W-1:0]    r_head_x;
    logic [COORD_W-1:0]    r_head_y;
    logic                  r_wall_hit;
    logic                  r_self_hit;

    logic [SEG_W-1:0]      w_seg;
    logic [COORD_W-1:0]    w_x_red;
    logic [COORD_W-1:0]    w_y_red;
    logic                  w_in_bounds;
    logic [CELLS-1:0]      w_mask;

    // Segment r_idx; r_idx is parked at 0 during CLEAR so the head decodes.
    assign w_seg = SEG_W'(r_snake_xy >> (32'(r_idx) * SEG_W));

    snake_cell_decode #(
        .SIZE_X (SIZE_X),
        .SIZE_Y (SIZE_Y),
        .CELLS  (CELLS)
    ) u_decode (
        .x         (seg_x(w_seg)),
        .y         (seg_y(w_seg)),
        .x_red     (w_x_red),
        .y_red     (w_y_red),
        .in_bounds (w_in_bounds),
        .mask      (w_mask)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_snake_xy <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_work     <= '0;
            r_head_x   <= '0;
            r_head_y   <= '0;
            r_wall_hit <= 1'b0;
            r_self_hit <= 1'b0;
            field      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            grow       <= 1'b0;
            collision  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (snake2field) begin
                        r_snake_xy <= snake_xy;
                        r_len      <= (lengh > c_cells) ? c_cells : lengh;
                        r_idx      <= '0;
                        busy       <= 1'b1;
                        r_state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_work     <= '0;
                    r_head_x   <= w_x_red;
                    r_head_y   <= w_y_red;
                    r_idx      <= '0;
                    r_wall_hit <= 1'b0;
                    r_self_hit <= 1'b0;
                    r_state    <= SCAN;
                end
                SCAN: begin
                    if (r_idx < r_len) begin
                        r_work <= r_work | w_mask;
                        if (r_idx == 16'd0) begin
`ifndef SNAKE_FIELD_WRAP_EN
                            // Only the head can hit a wall.
                            if (!w_in_bounds) r_wall_hit <= 1'b1;
`endif
                        end else if (w_x_red == r_head_x && w_y_red == r_head_y) begin
                            r_self_hit <= 1'b1;
                        end
                        r_idx <= r_idx + 16'd1;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    field     <= r_work;
                    grow      <= (r_len != 16'd0) && (r_head_x == food_x) &&
                                 (r_head_y == food_y) && !r_wall_hit;
                    collision <= r_wall_hit | r_self_hit;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
